// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the two-master SRAM arbiter
package mem_pkg;
  localparam int ADDR_W_DEF  = 20;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic {GNT_FETCH = 1'b0, GNT_DATA = 1'b1} gnt_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data request ports plus the SRAM controller command bus
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_pkg::DATA_W_DEF
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              d_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ready, if_err, d_rdata, d_ready, d_err, mem_addr, mem_wdata, mem_we, mem_re
  );
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ready, if_err, d_rdata, d_ready, d_err, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: WAIT-state cycle counter, saturating at the TIMEOUT terminal count
module mem_arb_timer #(
  parameter int TIMEOUT = mem_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] TC = W'(TIMEOUT);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && !tc_o) cnt_q <= cnt_q + 1'b1;
  end
  assign tc_o = cnt_q == TC;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges fetch (read-only) and data (read/write) masters onto one SRAM controller port.
// One single-cycle command per transaction; all outputs registered.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  state_e            state_q, state_d;
  gnt_e              last_q, last_d, gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic              if_rdy_q, if_rdy_d, if_err_q, if_err_d;
  logic              d_rdy_q, d_rdy_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              win, done, tc;
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q == S_ISSUE), .en_i(state_q == S_WAIT), .tc_o(tc)
  );
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;
    if_rdy_d   = 1'b0;
    if_err_d   = 1'b0;
    d_rdy_d    = 1'b0;
    d_err_d    = 1'b0;
    if_rdata_d = '0;
    d_rdata_d  = '0;
    // data wins unless fetch is also asking and round-robin says it's fetch's turn
    win  = bus.d_req && (!bus.if_req || !ROUND_ROBIN || last_q == GNT_FETCH);
    done = bus.mem_ready || (state_q == S_WAIT && tc);
    case (state_q)
      S_IDLE: if (bus.if_req || bus.d_req) begin
        state_d  = S_ISSUE;
        gnt_d    = win ? GNT_DATA : GNT_FETCH;
        last_d   = win ? GNT_DATA : GNT_FETCH;
        we_d     = win && bus.d_we;
        addr_d   = win ? bus.d_addr : bus.if_addr;
        wdata_d  = win ? bus.d_wdata : '0;
        mem_we_d = win && bus.d_we;
        mem_re_d = !(win && bus.d_we);
      end
      S_ISSUE, S_WAIT: if (done) begin
        state_d    = S_RESP;
        if_rdy_d   = gnt_q == GNT_FETCH;
        d_rdy_d    = gnt_q == GNT_DATA;
        if_err_d   = if_rdy_d && !bus.mem_ready;
        d_err_d    = d_rdy_d && !bus.mem_ready;
        if_rdata_d = (if_rdy_d && bus.mem_ready) ? bus.mem_rdata : '0;
        d_rdata_d  = (d_rdy_d && bus.mem_ready && !we_q) ? bus.mem_rdata : '0;
      end else if (state_q == S_ISSUE) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= GNT_FETCH;
      gnt_q      <= GNT_FETCH;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      if_rdy_q   <= 1'b0;
      if_err_q   <= 1'b0;
      d_rdy_q    <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      if_rdy_q   <= if_rdy_d;
      if_err_q   <= if_err_d;
      d_rdy_q    <= d_rdy_d;
      d_err_q    <= d_err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.if_ready  = if_rdy_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_rdy_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a 3-cycle controller model
module tb_mem_arbiter;
  import mem_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if b1();
  mem_arbiter_if b2();
  mem_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  mem_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  logic        hang1;
  logic [31:0] ctl_rd;
  logic [1:0]  sh1, sh2;
  assign b1.mem_rdata = ctl_rd;
  assign b2.mem_rdata = ctl_rd;
  // controller model: command seen, op, then registered ready three cycles after the command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh1 <= '0;
      sh2 <= '0;
      b1.mem_ready <= 1'b0;
      b2.mem_ready <= 1'b0;
    end else begin
      sh1 <= {sh1[0], b1.mem_re | b1.mem_we};
      sh2 <= {sh2[0], b2.mem_re | b2.mem_we};
      b1.mem_ready <= sh1[1] && !hang1;
      b2.mem_ready <= sh2[1];
    end
  end
  int re_cnt = 0, we_cnt = 0, ird_cnt = 0, drd_cnt = 0, both_cnt = 0;
  logic [19:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  always @(negedge clk) begin
    if (b1.mem_re) re_cnt <= re_cnt + 1;
    if (b1.mem_we) we_cnt <= we_cnt + 1;
    if (b1.mem_re || b1.mem_we) begin
      cap_addr  <= b1.mem_addr;
      cap_wdata <= b1.mem_wdata;
    end
    if ((b1.mem_re && b1.mem_we) || (b1.if_ready && b1.d_ready)) both_cnt <= both_cnt + 1;
    if (b1.if_ready) ird_cnt <= ird_cnt + 1;
    if (b1.d_ready) drd_cnt <= drd_cnt + 1;
  end
  int n_chk = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_rdy(input bit dport, output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (dport ? b1.d_ready : b1.if_ready) begin
        n = i;
        return;
      end
    end
  endtask
  int n, r0, w0, i0, d0, c1, c2;
  logic [3:0] g1;
  logic [4:0] g2;
  initial begin
    {b1.if_req, b1.d_req, b1.d_we, b2.if_req, b2.d_req, b2.d_we} = '0;
    b1.if_addr = '0; b1.d_addr = '0; b1.d_wdata = '0;
    b2.if_addr = '0; b2.d_addr = '0; b2.d_wdata = '0;
    hang1 = 1'b0;
    ctl_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {b1.mem_re, b1.mem_we, b1.if_ready, b1.if_err, b1.d_ready, b1.d_err}, 0);
    chk("rst_addr", b1.mem_addr, 0);
    chk("rst_rdata", b1.if_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single fetch
    ctl_rd = 32'hE59F1004; r0 = re_cnt;
    b1.if_addr = 20'h00100; b1.if_req = 1'b1;
    wait_rdy(1'b0, n);
    b1.if_req = 1'b0;
    chk("f_lat", n, 5);
    chk("f_rdata", b1.if_rdata, 32'hE59F1004);
    chk("f_err", b1.if_err, 0);
    chk("f_dready", b1.d_ready, 0);
    @(posedge clk);
    #1;
    chk("f_pulse", b1.if_ready, 0);
    chk("f_re_cnt", re_cnt - r0, 1);
    chk("f_addr", cap_addr, 20'h00100);
    // single write
    r0 = re_cnt; w0 = we_cnt; d0 = drd_cnt;
    b1.d_we = 1'b1; b1.d_addr = 20'h00200; b1.d_wdata = 32'hCAFEF00D; b1.d_req = 1'b1;
    wait_rdy(1'b1, n);
    b1.d_req = 1'b0; b1.d_we = 1'b0;
    chk("w_lat", n, 5);
    chk("w_rdata", b1.d_rdata, 0);
    chk("w_err", b1.d_err, 0);
    @(posedge clk);
    #1;
    chk("w_we_cnt", we_cnt - w0, 1);
    chk("w_re_cnt", re_cnt - r0, 0);
    chk("w_addr", cap_addr, 20'h00200);
    chk("w_wdata", cap_wdata, 32'hCAFEF00D);
    chk("w_rdy_cnt", drd_cnt - d0, 1);
    // fetch request held one cycle past ready starts a second transaction
    r0 = re_cnt; i0 = ird_cnt; ctl_rd = 32'h11223344;
    b1.if_addr = 20'h00300; b1.if_req = 1'b1;
    wait_rdy(1'b0, n);
    chk("h_lat1", n, 5);
    repeat (2) @(posedge clk);
    #1;
    b1.if_req = 1'b0;
    wait_rdy(1'b0, n);
    chk("h_lat2", n, 4);
    chk("h_rdata", b1.if_rdata, 32'h11223344);
    repeat (3) @(posedge clk);
    #1;
    chk("h_re_cnt", re_cnt - r0, 2);
    chk("h_rdy_cnt", ird_cnt - i0, 2);
    // timeout: 9 WAIT cycles then error response with zero data
    hang1 = 1'b1; ctl_rd = 32'hDEADBEEF;
    b1.d_addr = 20'h00400; b1.d_req = 1'b1;
    wait_rdy(1'b1, n);
    b1.d_req = 1'b0;
    chk("t_lat", n, 11);
    chk("t_err", b1.d_err, 1);
    chk("t_rdata", b1.d_rdata, 0);
    hang1 = 1'b0;
    @(posedge clk);
    #1;
    ctl_rd = 32'h0000A5A5; b1.d_addr = 20'h00404; b1.d_req = 1'b1;
    wait_rdy(1'b1, n);
    b1.d_req = 1'b0;
    chk("t2_lat", n, 5);
    chk("t2_err", b1.d_err, 0);
    chk("t2_rdata", b1.d_rdata, 32'h0000A5A5);
    @(posedge clk);
    #1;
    // reset in the middle of WAIT
    hang1 = 1'b1; i0 = ird_cnt;
    b1.if_addr = 20'h00500; b1.if_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_ctl", {b1.mem_re, b1.mem_we, b1.if_ready, b1.if_err, b1.d_ready, b1.d_err}, 0);
    chk("r_addr", b1.mem_addr, 0);
    hang1 = 1'b0; ctl_rd = 32'h0BADC0DE;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("r_no_rdy", ird_cnt - i0, 0);
    wait_rdy(1'b0, n);
    b1.if_req = 1'b0;
    chk("r_lat", n, 5);
    chk("r_rdata", b1.if_rdata, 32'h0BADC0DE);
    chk("r_addr2", cap_addr, 20'h00500);
    @(posedge clk);
    #1;
    // contention: dut1 round-robin, dut2 data priority
    c1 = 0; c2 = 0; g1 = '0; g2 = '0;
    b1.if_addr = 20'h00600; b1.d_addr = 20'h00700;
    b2.if_addr = 20'h00600; b2.d_addr = 20'h00700;
    {b1.if_req, b1.d_req, b2.if_req, b2.d_req} = 4'hF;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (c1 < 4 && (b1.if_ready || b1.d_ready)) begin
        g1[c1] = b1.d_ready;
        c1++;
        if (c1 == 4) {b1.if_req, b1.d_req} = 2'b00;
      end
      if (c2 < 5 && (b2.if_ready || b2.d_ready)) begin
        g2[c2] = b2.d_ready;
        c2++;
        if (c2 == 4) b2.d_req = 1'b0;
        if (c2 == 5) b2.if_req = 1'b0;
      end
      if (c1 == 4 && c2 == 5) break;
    end
    chk("rr_cnt", c1, 4);
    chk("rr_gnt", g1, 4'b0101);
    chk("fp_cnt", c2, 5);
    chk("fp_gnt", g2, 5'b01111);
    repeat (3) @(posedge clk);
    #1;
    chk("dual", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
